multi_alarm_set: RTL and testbench
==================================

MULTI_ALARM_SET -- requirements
Module: multi_alarm_set

Interface
REQ-001 SHALL have parameter N_ALARMS, default 4, number of alarm channels, legal range 2..16.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50_000_000, inc-held cycles before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_RATE, default 10_000_000, cycles between auto-repeat steps.
REQ-004 SHALL use one clock and an asynchronous active-low reset. Port list:
- clk  in  1  system clock, rising-edge.
- cr  in  1  asynchronous active-low reset.
- en  in  1  edit enable; 0 freezes FSM, buffer and repeat counter.
- alarm_sel  in  SW=$clog2(N_ALARMS)  channel to view/edit.
- field_sel  in  2  00 view, 01 minute, 10 hour, 11 treated as 00.
- inc  in  1  synchronous debounced level, increment request.
- dec  in  1  decrement request (present only with ALARM_DEC_EN).
- set_confirm  in  1  one-cycle pulse, commits edit buffer.
- arm_toggle  in  1  one-cycle pulse, toggles armed bit of alarm_sel.
- min_tick  in  1  one-cycle pulse at timebase minute rollover.
- cur_hour, cur_minute  in  8 each  current time, BCD.
- hour, minute  out  8 each  displayed alarm time, BCD.
- armed  out  N_ALARMS  per-channel armed flags.
- editing  out  1  high in EDIT state.
- alarm_hit  out  N_ALARMS  one-cycle match pulses.

Function
REQ-005 SHALL implement FSM {VIEW, EDIT}.
- VIEW->EDIT on en & field_sel in {01,10}: latch alarm_sel, load buffer from that channel.
- EDIT->VIEW on set_confirm (commit buffer to latched channel) or on field_sel in {00,11} (discard buffer).
REQ-006 SHALL ignore alarm_sel changes during EDIT; switching field_sel between 01 and 10 stays in EDIT and keeps the buffer.
REQ-007 SHALL step the buffer only in EDIT with en=1:
- minute field: BCD 00..59, 59->00.
- hour field: BCD 00..23, 23->00.
- no carry between fields.
REQ-008 SHALL step once on the cycle after an inc rising edge; while inc stays high, SHALL step again after REPEAT_DELAY cycles, then every REPEAT_RATE cycles; inc low clears the repeat counter.
REQ-009 SHALL drive hour/minute combinationally from the buffer in EDIT and from the alarm_sel channel registers in VIEW (zero latency).
REQ-010 SHALL toggle armed[alarm_sel] on arm_toggle in VIEW with en=1; arm_toggle SHALL be ignored in EDIT.
REQ-011 SHALL pulse alarm_hit[i] for one cycle, the cycle after min_tick, when armed[i]=1 and committed channel i equals {cur_hour, cur_minute}; matching SHALL be independent of en and state.
REQ-012 SHALL give set_confirm priority over a step in the same cycle: the pre-step buffer is committed and the step is discarded.
REQ-013 SHALL match a same-cycle min_tick and set_confirm on the same channel against the old stored value.
REQ-014 SHALL ignore set_confirm in VIEW.

Reset
REQ-015 SHALL on cr=0 asynchronously set: all channels 00:00, armed=0, alarm_hit=0, buffer 00:00, state VIEW, editing=0, repeat counter 0, edge detector cleared.
REQ-016 SHALL, on reset during EDIT, lose the uncommitted buffer and leave no partial commit.

Configuration
REQ-017 SHALL, with ALARM_DEC_EN defined, add port dec:
- dec steps the field downward (00->59 minute, 00->23 hour) with the same edge/repeat rules.
- inc and dec both high: no step, repeat counter cleared.
REQ-018 SHALL, without ALARM_DEC_EN, omit port dec and all decrement logic.

Verification
REQ-019 Reset mid-edit: buffer 12:34 in EDIT, cr low -> all outputs reset values, state VIEW, hour=00, minute=00.
REQ-020 Wrap: channel 2, field 01, buffer 59, inc pulse, set_confirm -> channel 2 minute=00, hour unchanged.
REQ-021 Auto-repeat (REPEAT_DELAY=10, REPEAT_RATE=3): inc held 19 cycles from 00 -> minute=04.
REQ-022 Match: channel 1 07:30 armed, cur=07:30, min_tick -> alarm_hit=4'b0010 for exactly one cycle; disarmed channel with the same time -> no pulse.
REQ-023 Abort: edit channel 0 to 05:00, field_sel->00 -> channel 0 keeps 00:00, editing=0.
REQ-024 Decrement (ALARM_DEC_EN): hour field at 00, dec pulse -> 23; inc+dec held -> value unchanged.

Source files
------------

// File: rtl/multi_alarm_set.sv
// Multi-channel alarm time store with VIEW/EDIT editing FSM, BCD stepping with auto-repeat,
// per-channel arming and minute-tick match pulses. Define ALARM_DEC_EN to add the dec port.
module multi_alarm_set #(
  parameter int unsigned N_ALARMS     = 4,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  localparam int unsigned SW          = $clog2(N_ALARMS)
) (
  input  logic                clk,
  input  logic                cr,
  input  logic                en,
  input  logic [SW-1:0]       alarm_sel,
  input  logic [1:0]          field_sel,
  input  logic                inc,
`ifdef ALARM_DEC_EN
  input  logic                dec,
`endif
  input  logic                set_confirm,
  input  logic                arm_toggle,
  input  logic                min_tick,
  input  logic [7:0]          cur_hour,
  input  logic [7:0]          cur_minute,
  output logic [7:0]          hour,
  output logic [7:0]          minute,
  output logic [N_ALARMS-1:0] armed,
  output logic                editing,
  output logic [N_ALARMS-1:0] alarm_hit
);

  typedef enum logic {VIEW, EDIT} state_t;

  localparam logic [31:0] RPT_FIRST = 32'(REPEAT_DELAY);
  localparam logic [31:0] RPT_NEXT  = 32'(REPEAT_DELAY + REPEAT_RATE);
  localparam logic [SW:0] N_CH      = (SW+1)'(N_ALARMS);

  state_t                     state_q, state_d;
  logic [SW-1:0]              sel_q, sel_d;
  logic [7:0]                 buf_hour_q, buf_hour_d;
  logic [7:0]                 buf_min_q, buf_min_d;
  logic [N_ALARMS-1:0][7:0]   ch_hour_q, ch_hour_d;
  logic [N_ALARMS-1:0][7:0]   ch_min_q, ch_min_d;
  logic [N_ALARMS-1:0]        armed_q, armed_d;
  logic [N_ALARMS-1:0]        hit_q, hit_d;
  logic [31:0]                rpt_cnt_q, rpt_cnt_d;
  logic                       inc_prev_q, inc_prev_d;
`ifdef ALARM_DEC_EN
  logic                       dec_prev_q, dec_prev_d;
  logic                       req_dn;
`endif

  logic [SW-1:0] view_idx;
  logic          field_edit;
  logic          req_any;
  logic          req_rise;
  logic          step;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)          return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

`ifdef ALARM_DEC_EN
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)        return max;
    if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction
`endif

  always_comb begin
    view_idx   = ({1'b0, alarm_sel} < N_CH) ? alarm_sel : '0;
    field_edit = (field_sel == 2'b01) || (field_sel == 2'b10);
`ifdef ALARM_DEC_EN
    // Opposing requests cancel: treated as no request, which also clears the repeat counter.
    req_any  = inc ^ dec;
    req_dn   = dec & ~inc;
    req_rise = req_dn ? ~dec_prev_q : ~inc_prev_q;
    dec_prev_d = dec;
`else
    req_any  = inc;
    req_rise = ~inc_prev_q;
`endif
    inc_prev_d = inc;
  end

  // Step pacing: one step on the request edge, then at REPEAT_DELAY and every REPEAT_RATE after.
  always_comb begin
    step      = 1'b0;
    rpt_cnt_d = rpt_cnt_q;
    if (state_q == EDIT && en) begin
      if (!req_any) begin
        rpt_cnt_d = '0;
      end else if (req_rise) begin
        rpt_cnt_d = '0;
        step      = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 32'd1;
        if (rpt_cnt_d == RPT_FIRST) begin
          step = 1'b1;
        end else if (rpt_cnt_d == RPT_NEXT) begin
          step      = 1'b1;
          rpt_cnt_d = RPT_FIRST;
        end
      end
      if (set_confirm || !field_edit) rpt_cnt_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    buf_hour_d = buf_hour_q;
    buf_min_d  = buf_min_q;
    ch_hour_d  = ch_hour_q;
    ch_min_d   = ch_min_q;
    armed_d    = armed_q;
    if (en) begin
      unique case (state_q)
        VIEW: begin
          if (arm_toggle) armed_d[view_idx] = ~armed_q[view_idx];
          if (field_edit) begin
            state_d    = EDIT;
            sel_d      = view_idx;
            buf_hour_d = ch_hour_q[view_idx];
            buf_min_d  = ch_min_q[view_idx];
          end
        end
        EDIT: begin
          if (set_confirm) begin
            ch_hour_d[sel_q] = buf_hour_q;
            ch_min_d[sel_q]  = buf_min_q;
            state_d          = VIEW;
          end else if (!field_edit) begin
            state_d = VIEW;
          end else if (step) begin
`ifdef ALARM_DEC_EN
            if (req_dn) begin
              if (field_sel == 2'b01) buf_min_d  = bcd_dec(buf_min_q, 8'h59);
              else                    buf_hour_d = bcd_dec(buf_hour_q, 8'h23);
            end else begin
              if (field_sel == 2'b01) buf_min_d  = bcd_inc(buf_min_q, 8'h59);
              else                    buf_hour_d = bcd_inc(buf_hour_q, 8'h23);
            end
`else
            if (field_sel == 2'b01) buf_min_d  = bcd_inc(buf_min_q, 8'h59);
            else                    buf_hour_d = bcd_inc(buf_hour_q, 8'h23);
`endif
          end
        end
      endcase
    end
  end

  // Matching uses the stored registers, so a same-cycle commit is compared at its old value.
  always_comb begin
    hit_d = '0;
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      hit_d[i] = min_tick && armed_q[i] &&
                 (ch_hour_q[i] == cur_hour) && (ch_min_q[i] == cur_minute);
    end
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      state_q    <= VIEW;
      sel_q      <= '0;
      buf_hour_q <= '0;
      buf_min_q  <= '0;
      ch_hour_q  <= '0;
      ch_min_q   <= '0;
      armed_q    <= '0;
      hit_q      <= '0;
      rpt_cnt_q  <= '0;
      inc_prev_q <= 1'b0;
`ifdef ALARM_DEC_EN
      dec_prev_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      buf_hour_q <= buf_hour_d;
      buf_min_q  <= buf_min_d;
      ch_hour_q  <= ch_hour_d;
      ch_min_q   <= ch_min_d;
      armed_q    <= armed_d;
      hit_q      <= hit_d;
      rpt_cnt_q  <= rpt_cnt_d;
      inc_prev_q <= inc_prev_d;
`ifdef ALARM_DEC_EN
      dec_prev_q <= dec_prev_d;
`endif
    end
  end

  always_comb begin
    editing   = (state_q == EDIT);
    hour      = editing ? buf_hour_q : ch_hour_q[view_idx];
    minute    = editing ? buf_min_q  : ch_min_q[view_idx];
    armed     = armed_q;
    alarm_hit = hit_q;
  end

endmodule

// File: tb/tb_multi_alarm_set.sv
// Directed self-checking bench for multi_alarm_set (short repeat timing: delay 10, rate 3).
module tb_multi_alarm_set;

  localparam int unsigned N = 4;

  logic         clk;
  logic         cr;
  logic         en;
  logic [1:0]   alarm_sel;
  logic [1:0]   field_sel;
  logic         inc;
`ifdef ALARM_DEC_EN
  logic         dec;
`endif
  logic         set_confirm;
  logic         arm_toggle;
  logic         min_tick;
  logic [7:0]   cur_hour;
  logic [7:0]   cur_minute;
  logic [7:0]   hour;
  logic [7:0]   minute;
  logic [N-1:0] armed;
  logic         editing;
  logic [N-1:0] alarm_hit;

  int unsigned n_tests;
  int unsigned n_fail;

  multi_alarm_set #(
    .N_ALARMS(N),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(3)
  ) dut (
    .clk(clk),
    .cr(cr),
    .en(en),
    .alarm_sel(alarm_sel),
    .field_sel(field_sel),
    .inc(inc),
`ifdef ALARM_DEC_EN
    .dec(dec),
`endif
    .set_confirm(set_confirm),
    .arm_toggle(arm_toggle),
    .min_tick(min_tick),
    .cur_hour(cur_hour),
    .cur_minute(cur_minute),
    .hour(hour),
    .minute(minute),
    .armed(armed),
    .editing(editing),
    .alarm_hit(alarm_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_inc(input int unsigned n);
    repeat (n) begin
      inc = 1'b1;
      tick(1);
      inc = 1'b0;
      tick(1);
    end
  endtask

  task automatic enter_edit(input logic [1:0] ch, input logic [1:0] fs);
    alarm_sel = ch;
    field_sel = fs;
    tick(1);
  endtask

  task automatic commit();
    set_confirm = 1'b1;
    tick(1);
    set_confirm = 1'b0;
    field_sel   = 2'b00;
    tick(1);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cr          = 1'b0;
    en          = 1'b0;
    alarm_sel   = 2'd0;
    field_sel   = 2'b00;
    inc         = 1'b0;
`ifdef ALARM_DEC_EN
    dec         = 1'b0;
`endif
    set_confirm = 1'b0;
    arm_toggle  = 1'b0;
    min_tick    = 1'b0;
    cur_hour    = 8'h00;
    cur_minute  = 8'h00;

    // Reset state
    #2;
    chk("rst_hour", 32'(hour), 32'h00);
    chk("rst_minute", 32'(minute), 32'h00);
    chk("rst_armed", 32'(armed), 32'h0);
    chk("rst_editing", 32'(editing), 32'h0);
    chk("rst_hit", 32'(alarm_hit), 32'h0);
    tick(2);
    cr = 1'b1;
    en = 1'b1;
    tick(1);

    // Abort: channel 0 hour edited to 05, then field 00 discards
    enter_edit(2'd0, 2'b10);
    chk("abort_editing_on", 32'(editing), 32'h1);
    pulse_inc(5);
    chk("abort_buf_hour", 32'(hour), 32'h05);
    field_sel = 2'b00;
    tick(1);
    chk("abort_editing_off", 32'(editing), 32'h0);
    chk("abort_ch0_hour", 32'(hour), 32'h00);
    chk("abort_ch0_minute", 32'(minute), 32'h00);

    // Wrap: channel 2 hour 03, minute 59 -> inc -> 00, committed
    enter_edit(2'd2, 2'b10);
    pulse_inc(3);
    field_sel = 2'b01;
    pulse_inc(59);
    chk("wrap_buf_59", 32'(minute), 32'h59);
    alarm_sel = 2'd1;
    #1;
    chk("wrap_sel_ignored_hour", 32'(hour), 32'h03);
    pulse_inc(1);
    chk("wrap_buf_00", 32'(minute), 32'h00);
    commit();
    chk("wrap_ch1_untouched", 32'(minute), 32'h00);
    alarm_sel = 2'd2;
    #1;
    chk("wrap_ch2_minute", 32'(minute), 32'h00);
    chk("wrap_ch2_hour", 32'(hour), 32'h03);

    // set_confirm beats a same-cycle step on channel 3
    enter_edit(2'd3, 2'b01);
    inc         = 1'b1;
    set_confirm = 1'b1;
    tick(1);
    inc         = 1'b0;
    set_confirm = 1'b0;
    field_sel   = 2'b00;
    tick(1);
    chk("prio_editing", 32'(editing), 32'h0);
    chk("prio_ch3_minute", 32'(minute), 32'h00);

    // en=0 freezes stepping, then auto-repeat over 19 held cycles
    enter_edit(2'd3, 2'b01);
    en = 1'b0;
    pulse_inc(1);
    chk("freeze_minute", 32'(minute), 32'h00);
    en  = 1'b1;
    inc = 1'b1;
    tick(10);
    chk("rpt_after10", 32'(minute), 32'h01);
    tick(9);
    chk("rpt_after19", 32'(minute), 32'h04);
    inc = 1'b0;
    tick(1);
    chk("rpt_release_hold", 32'(minute), 32'h04);
    commit();
    chk("rpt_ch3_commit", 32'(minute), 32'h04);

    // Hour wrap 23 -> 00 on channel 0 (aborted afterwards)
    enter_edit(2'd0, 2'b10);
    pulse_inc(23);
    chk("hour_23", 32'(hour), 32'h23);
    pulse_inc(1);
    chk("hour_wrap_00", 32'(hour), 32'h00);
    field_sel = 2'b00;
    tick(1);

    // Match: channel 1 and channel 0 both 07:30, only channel 1 armed
    enter_edit(2'd1, 2'b10);
    pulse_inc(7);
    field_sel = 2'b01;
    pulse_inc(30);
    commit();
    enter_edit(2'd0, 2'b10);
    pulse_inc(7);
    field_sel = 2'b01;
    pulse_inc(30);
    commit();
    alarm_sel  = 2'd1;
    arm_toggle = 1'b1;
    tick(1);
    arm_toggle = 1'b0;
    chk("arm_ch1", 32'(armed), 32'h2);
    cur_hour   = 8'h07;
    cur_minute = 8'h30;
    en         = 1'b0;
    min_tick   = 1'b1;
    tick(1);
    min_tick = 1'b0;
    chk("match_pulse", 32'(alarm_hit), 32'h2);
    tick(1);
    chk("match_one_cycle", 32'(alarm_hit), 32'h0);
    cur_minute = 8'h31;
    min_tick   = 1'b1;
    tick(1);
    min_tick = 1'b0;
    chk("nomatch_time", 32'(alarm_hit), 32'h0);
    en         = 1'b1;
    cur_minute = 8'h30;

    // Same-cycle commit and min_tick match the old stored 07:30
    enter_edit(2'd1, 2'b01);
    pulse_inc(1);
    chk("edit_buf_31", 32'(minute), 32'h31);
    arm_toggle = 1'b1;
    tick(1);
    arm_toggle = 1'b0;
    chk("arm_ignored_edit", 32'(armed), 32'h2);
    set_confirm = 1'b1;
    min_tick    = 1'b1;
    tick(1);
    set_confirm = 1'b0;
    min_tick    = 1'b0;
    field_sel   = 2'b00;
    chk("match_old_value", 32'(alarm_hit), 32'h2);
    tick(1);
    chk("commit_ch1_31", 32'(minute), 32'h31);
    min_tick = 1'b1;
    tick(1);
    min_tick = 1'b0;
    chk("match_after_commit", 32'(alarm_hit), 32'h0);

    // Reset mid-edit: channel 1 07:31 -> buffer 12:34, then cr low
    enter_edit(2'd1, 2'b10);
    pulse_inc(5);
    field_sel = 2'b01;
    pulse_inc(3);
    chk("mid_buf_hour", 32'(hour), 32'h12);
    chk("mid_buf_minute", 32'(minute), 32'h34);
    #2;
    cr = 1'b0;
    #1;
    chk("mid_rst_hour", 32'(hour), 32'h00);
    chk("mid_rst_minute", 32'(minute), 32'h00);
    chk("mid_rst_editing", 32'(editing), 32'h0);
    chk("mid_rst_armed", 32'(armed), 32'h0);
    chk("mid_rst_hit", 32'(alarm_hit), 32'h0);
    field_sel = 2'b00;
    tick(1);
    cr = 1'b1;
    tick(1);
    chk("post_rst_ch1_minute", 32'(minute), 32'h00);

`ifdef ALARM_DEC_EN
    // Decrement wraps and opposing requests cancel
    enter_edit(2'd0, 2'b10);
    dec = 1'b1;
    tick(1);
    dec = 1'b0;
    tick(1);
    chk("dec_hour_23", 32'(hour), 32'h23);
    inc = 1'b1;
    dec = 1'b1;
    tick(5);
    chk("incdec_hold", 32'(hour), 32'h23);
    inc = 1'b0;
    dec = 1'b0;
    tick(1);
    field_sel = 2'b01;
    dec = 1'b1;
    tick(1);
    dec = 1'b0;
    tick(1);
    chk("dec_minute_59", 32'(minute), 32'h59);
    field_sel = 2'b00;
    tick(1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
